// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module  : alu_seq_pkg
// Brief   : Shared types and constants for the alu_sequencer block
//           (opcode decode bits, sequencer state encoding, default width).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam int WIDTH_DEF = 4;

  // Opcode field bit positions.
  //   op[1]=1 : ABS, op[2] picks operand (1: A, 0: B)
  //   op[1]=0 : add/sub, op[0]=1 subtract, op[2] swaps to B-A when subtracting
  localparam int OP_BIT_SUB  = 0;
  localparam int OP_BIT_ABS  = 1;
  localparam int OP_BIT_SELA = 2;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_ADD_ALT = 3'b100;
  localparam logic [2:0] OP_SUB_AB  = 3'b001;
  localparam logic [2:0] OP_SUB_BA  = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    ABS_NEG = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage : alu_seq_pkg

`default_nettype wire

// File: rtl/alu_addsub_core.sv
// ============================================================================
// Module  : alu_addsub_core
// Brief   : Combinational two's-complement adder/subtractor with signed
//           overflow (carry into MSB XOR carry out of MSB).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_addsub_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] y_eff;
  logic [WIDTH-1:0] low;    // low bits sum; MSB of this vector is carry into MSB
  logic [1:0]       top;    // {carry out, MSB of sum}

  // Subtract is X + ~Y + 1; split the add so both MSB carries are visible.
  always_comb begin
    y_eff = y ^ {WIDTH{sub}};
    low   = {1'b0, x[WIDTH-2:0]} + {1'b0, y_eff[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, sub};
    top   = {1'b0, x[WIDTH-1]} + {1'b0, y_eff[WIDTH-1]} + {1'b0, low[WIDTH-1]};
    sum   = {top[0], low[WIDTH-2:0]};
    ovf   = low[WIDTH-1] ^ top[1];
  end

endmodule : alu_addsub_core

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module  : alu_sequencer
// Brief   : Command-driven sequencer around one shared add/sub datapath.
//           ADD/SUB take one pass, ABS takes one or two passes. Keeps an
//           accumulator and a sticky overflow flag.
//           Optional macro ALU_SAT_EN: saturate overflowing results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_acc,
  input  logic             cmd_clr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic [WIDTH-1:0] acc,
  output logic             ovf_sticky
);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_ovf_q, res_ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;

  logic [WIDTH-1:0] core_x, core_y, core_sum;
  logic             core_sub, core_ovf;
  logic [WIDTH-1:0] abs_operand;
  logic [WIDTH-1:0] result_fix;
  logic             is_abs;

  alu_addsub_core #(.WIDTH(WIDTH)) u_core (
    .x   (core_x),
    .y   (core_y),
    .sub (core_sub),
    .sum (core_sum),
    .ovf (core_ovf)
  );

  // Result correction: wrap by default, clamp toward the true sign when saturating.
  always_comb begin
`ifdef ALU_SAT_EN
    if (core_ovf) begin
      // On overflow the true sign is the opposite of the wrapped MSB.
      result_fix = core_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                     : {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      result_fix = core_sum;
    end
`else
    result_fix = core_sum;
`endif
  end

  // Next-state, operand muxing for the shared core, and result commit.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    acc_d      = acc_q;
    sticky_d   = sticky_q;
    core_x     = a_q;
    core_y     = b_q;
    core_sub   = 1'b0;

    is_abs      = op_q[OP_BIT_ABS];
    abs_operand = op_q[OP_BIT_SELA] ? a_q : b_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = EXEC;
          op_d    = cmd_op;
          a_d     = cmd_acc ? acc_q : cmd_a;
          b_d     = cmd_b;
          // Clear happens here; the overflow of this command is ORed in later.
          if (cmd_clr) begin
            sticky_d = 1'b0;
          end
        end
      end

      EXEC: begin
        if (is_abs) begin
          // Non-negative ABS passes the operand through (X + 0, no overflow).
          core_x = abs_operand;
          core_y = '0;
        end else if (op_q[OP_BIT_SUB]) begin
          core_sub = 1'b1;
          if (op_q[OP_BIT_SELA]) begin
            core_x = b_q;
            core_y = a_q;
          end
        end

        if (is_abs && abs_operand[WIDTH-1]) begin
          state_d = ABS_NEG;
        end else begin
          state_d    = DONE;
          res_data_d = result_fix;
          res_ovf_d  = core_ovf;
          acc_d      = result_fix;
          sticky_d   = sticky_q | core_ovf;
        end
      end

      ABS_NEG: begin
        // Second pass computes 0 - X; only the most negative value overflows.
        core_x     = '0;
        core_y     = abs_operand;
        core_sub   = 1'b1;
        state_d    = DONE;
        res_data_d = result_fix;
        res_ovf_d  = core_ovf;
        acc_d      = result_fix;
        sticky_d   = sticky_q | core_ovf;
      end

      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      acc_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      acc_q      <= acc_d;
      sticky_q   <= sticky_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign res_valid  = (state_q == DONE);
  assign res_data   = res_data_q;
  assign res_ovf    = res_ovf_q;
  assign acc        = acc_q;
  assign ovf_sticky = sticky_q;

endmodule : alu_sequencer

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module  : tb_alu_sequencer
// Brief   : Self-checking bench for alu_sequencer: directed vector table,
//           hand-written hold/reset sequences and randomized commands
//           against an integer-arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_acc;
  logic       cmd_clr;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_ovf;
  logic [3:0] acc;
  logic       ovf_sticky;

  alu_sequencer #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_acc    (cmd_acc),
    .cmd_clr    (cmd_clr),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_ovf    (res_ovf),
    .acc        (acc),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: accumulator and sticky flag as the spec defines them.
  logic [3:0] m_acc;
  logic       m_sticky;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       accs;
    logic       clr;
    logic [3:0] d;
    logic       o;
    int         lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Spec-level model: exact signed integer result, then range test / wrap / clamp.
  function automatic void ref_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                    output logic [3:0] d, output logic o, output int lat);
    int x, y, r, v;
    x   = $signed(a);
    y   = $signed(b);
    lat = 2;
    case (op)
      3'b000, 3'b100: r = x + y;
      3'b001:         r = x - y;
      3'b101:         r = y - x;
      default: begin
        v   = op[2] ? x : y;
        r   = (v < 0) ? -v : v;
        lat = (v < 0) ? 3 : 2;
      end
    endcase
    o = (r > 7) || (r < -8);
    if (o && SAT) d = (r > 0) ? 4'b0111 : 4'b1000;
    else          d = 4'(r);
  endfunction

  // Issue one command, measure latency, optionally hold res_ready low, then consume.
  task automatic run(input string tag, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                     input logic accs, input logic clr, input int hold,
                     input logic [3:0] ed, input logic eo, input int el);
    int n;
    int lat;
    logic [3:0] got_d;
    @(negedge clk);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = accs; cmd_clr = clr; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk({tag, "_ready_timeout"}, 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (clr) m_sticky = 1'b0;
    m_acc    = ed;
    m_sticky = m_sticky | eo;
    chk({tag, "_lat"},    lat,        el);
    chk({tag, "_data"},   res_data,   ed);
    chk({tag, "_ovf"},    res_ovf,    eo);
    chk({tag, "_acc"},    acc,        m_acc);
    chk({tag, "_sticky"}, ovf_sticky, m_sticky);
    got_d = res_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, res_valid, 1);
      chk({tag, "_hold_data"},  res_data,  got_d);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_ready_after"}, {res_valid, cmd_ready}, 2'b01);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready,  1);
    chk({tag, "_res_valid"}, res_valid,  0);
    chk({tag, "_res_data"},  res_data,   0);
    chk({tag, "_res_ovf"},   res_ovf,    0);
    chk({tag, "_acc"},       acc,        0);
    chk({tag, "_sticky"},    ovf_sticky, 0);
  endtask

  initial begin
    logic [3:0] rd, a_eff;
    logic       ro;
    int         rl;
    logic [2:0] op;
    logic [3:0] ra, rb;
    logic       ras, rcl;
    int         n;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_acc = 1'b0; cmd_clr = 1'b0; res_ready = 1'b0;
    m_acc = '0; m_sticky = 1'b0;

    tbl[0] = '{3'b000, 4'd3,    4'd4,    1'b0, 1'b0, 4'b0111, 1'b0, 2};
    tbl[1] = '{3'b000, 4'd5,    4'd4,    1'b0, 1'b0, SAT ? 4'b0111 : 4'b1001, 1'b1, 2};
    tbl[2] = '{3'b001, 4'd2,    4'd5,    1'b0, 1'b0, 4'b1101, 1'b0, 2};
    tbl[3] = '{3'b101, 4'd2,    4'd5,    1'b0, 1'b0, 4'b0011, 1'b0, 2};
    tbl[4] = '{3'b110, 4'b1011, 4'd0,    1'b0, 1'b0, 4'b0101, 1'b0, 3};
    tbl[5] = '{3'b010, 4'd0,    4'b0110, 1'b0, 1'b0, 4'b0110, 1'b0, 2};
    tbl[6] = '{3'b111, 4'b1000, 4'd3,    1'b0, 1'b0, SAT ? 4'b0111 : 4'b1000, 1'b1, 3};
    tbl[7] = '{3'b000, 4'd3,    4'd4,    1'b0, 1'b0, 4'b0111, 1'b0, 2};
    tbl[8] = '{3'b000, 4'd5,    4'd1,    1'b1, 1'b0, SAT ? 4'b0111 : 4'b1000, 1'b1, 2};
    tbl[9] = '{3'b000, 4'd1,    4'd1,    1'b0, 1'b1, 4'b0010, 1'b0, 2};

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      run($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].accs, tbl[i].clr,
          (i == 0) ? 2 : 0, tbl[i].d, tbl[i].o, tbl[i].lat);
    end
    chk("clr_sticky_zero", ovf_sticky, 0);

    // Result held 5 cycles with a competing command that must be ignored.
    @(negedge clk);
    cmd_op = 3'b000; cmd_a = 4'd2; cmd_b = 4'd3; cmd_acc = 1'b0; cmd_clr = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("hold_lat", n, 2);
    cmd_op = 3'b001; cmd_a = 4'd7; cmd_b = 4'd1; cmd_clr = 1'b1; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data",  res_data,  4'b0101);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0; cmd_clr = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    m_acc = 4'b0101;
    chk("hold_acc", acc, 4'b0101);
    @(negedge clk);
    chk("hold_no_extra_result", res_valid, 0);

    // Build sticky up, then reset in EXEC: command dropped, everything back to reset values.
    run("pre_rst", 3'b000, 4'd7, 4'd7, 1'b0, 1'b0, 0, SAT ? 4'b0111 : 4'b1110, 1'b1, 2);
    @(negedge clk);
    cmd_op = 3'b000; cmd_a = 4'd1; cmd_b = 4'd1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("rst_exec");
    m_acc = '0; m_sticky = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_dropped", res_valid, 0);
    end

    // Randomized commands against the reference model.
    for (int k = 0; k < 150; k++) begin
      op  = 3'($urandom_range(0, 7));
      ra  = 4'($urandom);
      rb  = 4'($urandom);
      ras = ($urandom_range(0, 3) == 0);
      rcl = ($urandom_range(0, 3) == 0);
      a_eff = ras ? m_acc : ra;
      ref_model(op, a_eff, rb, rd, ro, rl);
      run($sformatf("rnd%0d", k), op, ra, rb, ras, rcl, $urandom_range(0, 3), rd, ro, rl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_sequencer

`default_nettype wire
